// File: rtl/etapa_ex_operandos.sv
// Operand staging buffer between register read and the ALU: main + skid entry, registered in_ready.
// Define FORWARD_EN to patch captured and held operands with late register-file writebacks.
module etapa_ex_operandos #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    Op1_in,
  input  logic [WIDTH-1:0]    Op2_in,
  input  logic [2:0]          AluOp_in,
  input  logic [REG_BITS-1:0] Rs1_in,
  input  logic [REG_BITS-1:0] Rs2_in,
  input  logic [REG_BITS-1:0] Rd_in,
  input  logic                RegWrite_in,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    Op1,
  output logic [WIDTH-1:0]    Op2,
  output logic [2:0]          AluOp,
  output logic [REG_BITS-1:0] Rd,
  output logic                RegWrite,
  input  logic                WbEn,
  input  logic [REG_BITS-1:0] WbRd,
  input  logic [WIDTH-1:0]    WbData
);

  typedef struct packed {
    logic [WIDTH-1:0]    op1;
    logic [WIDTH-1:0]    op2;
    logic [2:0]          aluop;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [REG_BITS-1:0] rd;
    logic                regwrite;
  } entry_t;

  entry_t r_main, r_skid;
  logic   r_main_v, r_skid_v, r_in_ready;

  entry_t w_in, w_main_nx, w_skid_nx;
  logic   w_main_v_nx, w_skid_v_nx;
  logic   w_accept, w_consume, w_main_load, w_wb_hit;

`ifdef FORWARD_EN
  assign w_wb_hit = WbEn & (WbRd != '0);
`else
  logic w_unused;
  assign w_wb_hit = 1'b0;
  assign w_unused = WbEn;
`endif

  function automatic entry_t fwd(input entry_t e, input logic hit,
                                 input logic [REG_BITS-1:0] rd,
                                 input logic [WIDTH-1:0] data);
    entry_t r;
    r = e;
    if (hit && e.rs1 == rd) r.op1 = data;
    if (hit && e.rs2 == rd) r.op2 = data;
    return r;
  endfunction

  assign w_in = '{op1: Op1_in, op2: Op2_in, aluop: AluOp_in, rs1: Rs1_in,
                  rs2: Rs2_in, rd: Rd_in, regwrite: RegWrite_in};

  assign w_accept    = in_valid & r_in_ready;
  assign w_consume   = r_main_v & out_ready;
  assign w_main_load = w_consume | ~r_main_v;

  // Skid always drains into main before new input may reach main, preserving order.
  always_comb begin
    w_main_v_nx = r_main_v;
    w_main_nx   = r_main;
    w_skid_v_nx = r_skid_v;
    w_skid_nx   = r_skid;

    if (w_main_load) begin
      if (r_skid_v) begin
        w_main_v_nx = 1'b1;
        w_main_nx   = fwd(r_skid, w_wb_hit, WbRd, WbData);
        w_skid_v_nx = 1'b0;
      end else if (w_accept) begin
        w_main_v_nx = 1'b1;
        w_main_nx   = fwd(w_in, w_wb_hit, WbRd, WbData);
      end else begin
        w_main_v_nx = 1'b0;
      end
    end else begin
      w_main_nx = fwd(r_main, w_wb_hit, WbRd, WbData);
      if (w_accept) begin
        w_skid_v_nx = 1'b1;
        w_skid_nx   = fwd(w_in, w_wb_hit, WbRd, WbData);
      end
    end

    if (r_skid_v && w_skid_v_nx)
      w_skid_nx = fwd(r_skid, w_wb_hit, WbRd, WbData);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_v   <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_main <= w_main_nx;
      r_skid <= w_skid_nx;
      if (flush) begin
        r_main_v   <= 1'b0;
        r_skid_v   <= 1'b0;
        r_in_ready <= 1'b1;
      end else begin
        r_main_v   <= w_main_v_nx;
        r_skid_v   <= w_skid_v_nx;
        r_in_ready <= ~w_skid_v_nx;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_main_v;
  assign Op1       = r_main.op1;
  assign Op2       = r_main.op2;
  assign AluOp     = r_main.aluop;
  assign Rd        = r_main.rd;
  assign RegWrite  = r_main.regwrite;

endmodule

// File: tb/tb_etapa_ex_operandos.sv
// Directed self-checking bench for etapa_ex_operandos; expectations are hand-computed per step.
module tb_etapa_ex_operandos;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] Op1_in, Op2_in, Op1, Op2, WbData;
  logic [2:0]  AluOp_in, AluOp;
  logic [4:0]  Rs1_in, Rs2_in, Rd_in, Rd, WbRd;
  logic        RegWrite_in, RegWrite, WbEn;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_fwd1, exp_fwd2;

  etapa_ex_operandos #(.WIDTH(32), .REG_BITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Op1_in(Op1_in), .Op2_in(Op2_in), .AluOp_in(AluOp_in),
    .Rs1_in(Rs1_in), .Rs2_in(Rs2_in), .Rd_in(Rd_in), .RegWrite_in(RegWrite_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .Op1(Op1), .Op2(Op2), .AluOp(AluOp), .Rd(Rd), .RegWrite(RegWrite),
    .WbEn(WbEn), .WbRd(WbRd), .WbData(WbData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw);
    in_valid = 1'b1; Op1_in = a; Op2_in = b; AluOp_in = op;
    Rs1_in = rs1; Rs2_in = rs2; Rd_in = rd; RegWrite_in = rw;
  endtask

  initial begin
`ifdef FORWARD_EN
    exp_fwd1 = 32'hAA; exp_fwd2 = 32'hCC;
`else
    exp_fwd1 = 32'h10; exp_fwd2 = 32'h20;
`endif
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    Op1_in = '0; Op2_in = '0; AluOp_in = '0; Rs1_in = '0; Rs2_in = '0;
    Rd_in = '0; RegWrite_in = 1'b0; WbEn = 1'b0; WbRd = '0; WbData = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_ready", {31'b0, in_ready}, 1);
    check("rst_op1", Op1, 0);
    check("rst_op2", Op2, 0);
    check("rst_alu", {29'b0, AluOp}, 0);
    check("rst_rd", {27'b0, Rd}, 0);
    check("rst_rw", {31'b0, RegWrite}, 0);

    // streaming at full rate
    out_ready = 1'b1;
    drive(32'd5, 32'd3, 3'b010, 5'd1, 5'd2, 5'd3, 1'b1);
    tick();
    check("strA_valid", {31'b0, out_valid}, 1);
    check("strA_op1", Op1, 5);
    check("strA_op2", Op2, 3);
    check("strA_alu", {29'b0, AluOp}, 2);
    check("strA_rd", {27'b0, Rd}, 3);
    check("strA_rw", {31'b0, RegWrite}, 1);
    check("strA_ready", {31'b0, in_ready}, 1);
    drive(32'd100, 32'd7, 3'b001, 5'd4, 5'd5, 5'd4, 1'b1);
    tick();
    check("strB_op1", Op1, 100);
    check("strB_alu", {29'b0, AluOp}, 1);
    check("strB_ready", {31'b0, in_ready}, 1);
    drive(32'hFFFF_FFFF, 32'd1, 3'b011, 5'd6, 5'd7, 5'd5, 1'b0);
    tick();
    check("strC_op1", Op1, 32'hFFFF_FFFF);
    check("strC_rd", {27'b0, Rd}, 5);
    check("strC_rw", {31'b0, RegWrite}, 0);
    check("strC_ready", {31'b0, in_ready}, 1);
    in_valid = 1'b0;
    tick();
    check("str_drain", {31'b0, out_valid}, 0);

    // stall: A held in main, B in skid, C refused
    out_ready = 1'b0;
    drive(32'd11, 32'd22, 3'b000, 5'd1, 5'd1, 5'd6, 1'b1);
    tick();
    check("stA_op1", Op1, 11);
    check("stA_ready", {31'b0, in_ready}, 1);
    drive(32'd33, 32'd44, 3'b100, 5'd2, 5'd2, 5'd7, 1'b1);
    tick();
    check("stB_op1_held", Op1, 11);
    check("stB_ready", {31'b0, in_ready}, 0);
    drive(32'd55, 32'd66, 3'b001, 5'd3, 5'd3, 5'd8, 1'b1);
    tick();
    check("stC_op1_held", Op1, 11);
    check("stC_ready", {31'b0, in_ready}, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("stB_out_op1", Op1, 33);
    check("stB_out_alu", {29'b0, AluOp}, 4);
    check("stB_out_rd", {27'b0, Rd}, 7);
    check("stB_out_ready", {31'b0, in_ready}, 1);
    tick();
    check("st_drain", {31'b0, out_valid}, 0);
    check("st_drain_ready", {31'b0, in_ready}, 1);

    // flush with both entries full
    out_ready = 1'b0;
    drive(32'd1, 32'd1, 3'b010, 5'd1, 5'd1, 5'd1, 1'b1);
    tick();
    drive(32'd2, 32'd2, 3'b010, 5'd1, 5'd1, 5'd2, 1'b1);
    tick();
    check("fl_full_ready", {31'b0, in_ready}, 0);
    in_valid = 1'b0; flush = 1'b1;
    tick();
    check("fl_valid", {31'b0, out_valid}, 0);
    check("fl_ready", {31'b0, in_ready}, 1);
    flush = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_after1", {31'b0, out_valid}, 0);
    tick();
    check("fl_after2", {31'b0, out_valid}, 0);

    // writeback patching of a held operand (ignored without FORWARD_EN)
    out_ready = 1'b0;
    drive(32'h10, 32'h20, 3'b010, 5'd7, 5'd3, 5'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    WbEn = 1'b1; WbRd = 5'd7; WbData = 32'hAA;
    tick();
    check("fw_rs1_op1", Op1, exp_fwd1);
    check("fw_rs1_op2", Op2, 32'h20);
    WbRd = 5'd0; WbData = 32'hBB;
    tick();
    check("fw_r0_op1", Op1, exp_fwd1);
    WbRd = 5'd3; WbData = 32'hCC;
    tick();
    check("fw_rs2_op1", Op1, exp_fwd1);
    check("fw_rs2_op2", Op2, exp_fwd2);
    out_ready = 1'b1; WbRd = 5'd0; WbData = 32'hDD;
    drive(32'h30, 32'h40, 3'b000, 5'd0, 5'd0, 5'd10, 1'b0);
    tick();
    check("fw_cap_r0_op1", Op1, 32'h30);
    check("fw_cap_r0_op2", Op2, 32'h40);
    in_valid = 1'b0; WbEn = 1'b0;
    tick();
    check("fw_drain", {31'b0, out_valid}, 0);

    // asynchronous reset with skid full
    out_ready = 1'b0;
    drive(32'h77, 32'h88, 3'b011, 5'd1, 5'd2, 5'd11, 1'b1);
    tick();
    drive(32'h99, 32'h12, 3'b001, 5'd1, 5'd2, 5'd12, 1'b1);
    tick();
    check("ar_pre_ready", {31'b0, in_ready}, 0);
    check("ar_pre_op1", Op1, 32'h77);
    rst = 1'b1;
    #1;
    check("ar_valid", {31'b0, out_valid}, 0);
    check("ar_ready", {31'b0, in_ready}, 1);
    check("ar_op1", Op1, 0);
    check("ar_op2", Op2, 0);
    check("ar_alu", {29'b0, AluOp}, 0);
    check("ar_rd", {27'b0, Rd}, 0);
    check("ar_rw", {31'b0, RegWrite}, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("ar_post_valid", {31'b0, out_valid}, 0);
    check("ar_post_ready", {31'b0, in_ready}, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/etapa_ex_operandos.md
# etapa_ex_operandos

Operand staging buffer between the decode/register-read logic and the ALU. Captures a decoded operation (two 32-bit operands, 3-bit ALU opcode, destination register and write enable) with a valid/ready handshake, and holds it stable on the ALU inputs until the execute side accepts it. A two-entry skid arrangement lets the upstream ready stay registered with no bubble at full throughput. Optionally patches held operands with late register-file writebacks.

## Interface
- WIDTH, 32, operand width (ALU operand width)
- REG_BITS, 5, register index width
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  buffer can accept this cycle (registered)
- Op1_in, Op2_in  input  WIDTH  operands from register read
- AluOp_in  input  3  ALU opcode (000 AND, 001 OR, 010 ADD, 011 SUB, 100 SGT)
- Rs1_in, Rs2_in  input  REG_BITS  source indices of Op1_in/Op2_in
- Rd_in  input  REG_BITS  destination index
- RegWrite_in  input  1  operation writes Rd
- flush  input  1  discard all held and incoming operations
- out_valid  output  1  Op1/Op2/AluOp/Rd/RegWrite valid
- out_ready  input  1  execute side consumes this cycle
- Op1, Op2  output  WIDTH  operands to ALU
- AluOp  output  3  opcode to ALU
- Rd  output  REG_BITS; RegWrite  output  1  passed through to writeback
- WbEn  input  1; WbRd  input  REG_BITS; WbData  input  WIDTH  writeback port (used only with forwarding)

## Operation
- State: main entry (drives outputs, flag main_v = out_valid) and skid entry (flag skid_v); each entry holds Op1, Op2, AluOp, Rs1, Rs2, Rd, RegWrite.
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- Next main: if consume or !main_v: skid entry if skid_v, else incoming if accept, else empty. Otherwise unchanged.
- Next skid: set with incoming when accept & main_v & !consume; cleared when it moves to main; otherwise unchanged.
- Accept while skid_v cannot occur (in_ready=0). in_ready <= !(next skid_v).
- Order preserved: skid always drains to main before new input reaches main.
- flush: at the edge, main_v=0, skid_v=0, in_ready=1; any accept/consume that cycle is discarded upstream/downstream responsibility (consume still counts as taken by execute).
- Entry fields not valid hold last value; only flags are cleared.

## Timing
- Reset values: out_valid 0, in_ready 1, Op1 0, Op2 0, AluOp 000, Rd 0, RegWrite 0; skid_v 0.
- Latency: accepted op appears on outputs one cycle later when main is empty or consumed.
- Throughput: one op/cycle with out_ready held high.
- out_ready low with main full: one further op absorbed into skid, in_ready low from the following cycle.
- Simultaneous accept and consume with skid empty: incoming moves directly to main, no skid use.
- Outputs are registered; no combinational path from in_* to out_* or from out_ready to in_ready.
- Reset mid-operation discards both entries immediately.

## Configuration
- FORWARD_EN defined: when WbEn=1 and WbRd!=0, each operand whose source index equals WbRd is replaced by WbData: on incoming data at capture, and on held main/skid entries at every edge (including skid moving into main). Rs1 and Rs2 checked independently.
- FORWARD_EN undefined: WbEn/WbRd/WbData ignored; operands stored exactly as captured.

## Test plan
- Reset asserted, then released -> out_valid 0, in_ready 1, Op1=Op2=0, AluOp 000.
- Stream ops A(Op1=5,Op2=3,AluOp=010), B, C with out_ready=1 -> A on outputs cycle after accept, B and C back-to-back, in_ready stays 1.
- out_ready=0, present A then B -> A held on outputs, B in skid, in_ready 0; raise out_ready -> A then B emitted, in_ready returns 1.
- Two entries full, assert flush -> next cycle out_valid 0, in_ready 1; previously held ops never appear.
- FORWARD_EN: hold op with Rs1=7, Op1=0x10 stalled; WbEn=1, WbRd=7, WbData=0xAA -> Op1 becomes 0xAA next cycle; repeat with WbRd=0 -> Op1 unchanged.
- rst asserted while skid full mid-stream -> outputs immediately return to reset values, in_ready 1.
